// File: rtl/gpu_pkg.sv
// Shared GPU pipeline types: register-file geometry, writeback source tags
// and the load-return queue entry layout.
package gpu_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned NUM_GPR    = 13;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LD
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } ld_entry_t;

endpackage

// File: rtl/wb_ldq.sv
// Load-return queue for the writeback stage: strict FIFO of ld_entry_t with
// synchronous active-low reset. Push when full and pop when empty are ignored.
module wb_ldq
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  ld_entry_t              push_data,
  input  logic                   pop,
  output ld_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned    PW   = $clog2(DEPTH);
  localparam logic [PW:0]    FULL = (PW+1)'(DEPTH);

  ld_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < FULL);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU results win over queued load returns, registered
// write port, pending-load scoreboard. Drop counter enabled by WB_DROP_CNT_EN.
module writeback_arbiter #(
  parameter int unsigned DATA_W    = gpu_pkg::DATA_W,
  parameter int unsigned ADDR_W    = gpu_pkg::REG_ADDR_W,
  parameter int unsigned NUM_GPR   = gpu_pkg::NUM_GPR,
  parameter int unsigned LDQ_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alu_valid,
  input  logic [ADDR_W-1:0]              alu_rd,
  input  logic [DATA_W-1:0]              alu_data,
  input  logic                           issue_load,
  input  logic [ADDR_W-1:0]              issue_rd,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [ADDR_W-1:0]              ld_rd,
  input  logic [DATA_W-1:0]              ld_data,
  output logic                           reg_en,
  output logic                           we,
  output logic [ADDR_W-1:0]              A3,
  output logic [DATA_W-1:0]              WD,
  output logic [NUM_GPR-1:0]             pending,
  output logic [$clog2(LDQ_DEPTH):0]     ldq_count,
  output logic [7:0]                     drop_cnt
);

  localparam int unsigned         CW    = $clog2(LDQ_DEPTH) + 1;
  localparam logic [ADDR_W-1:0]   GPR_N = ADDR_W'(NUM_GPR);

  gpu_pkg::ld_entry_t push_e;
  gpu_pkg::ld_entry_t head_e;
  gpu_pkg::wb_src_e   wb_src;
  logic               alu_wr;
  logic               pop;
  logic               head_ok;
  logic [NUM_GPR-1:0] pending_nxt;

  assign push_e.rd   = ld_rd;
  assign push_e.data = ld_data;

  assign ld_ready = (ldq_count < CW'(LDQ_DEPTH));
  assign alu_wr   = alu_valid && (alu_rd < GPR_N);
  assign pop      = !alu_wr && (ldq_count != '0);
  assign head_ok  = head_e.rd < GPR_N;

  wb_ldq #(
    .DEPTH (LDQ_DEPTH)
  ) u_ldq (
    .clk       (clk),
    .reset     (reset),
    .push      (ld_valid && ld_ready),
    .push_data (push_e),
    .pop       (pop),
    .head      (head_e),
    .count     (ldq_count)
  );

  // A3/WD only load on a real write so they hold while idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we     <= 1'b0;
      reg_en <= 1'b0;
      A3     <= '0;
      WD     <= '0;
      wb_src <= gpu_pkg::WB_NONE;
    end else if (alu_wr) begin
      we     <= 1'b1;
      reg_en <= 1'b1;
      A3     <= alu_rd;
      WD     <= alu_data;
      wb_src <= gpu_pkg::WB_ALU;
    end else if (pop && head_ok) begin
      we     <= 1'b1;
      reg_en <= 1'b1;
      A3     <= head_e.rd;
      WD     <= head_e.data;
      wb_src <= gpu_pkg::WB_LD;
    end else begin
      we     <= 1'b0;
      reg_en <= 1'b0;
      wb_src <= gpu_pkg::WB_NONE;
    end
  end

  // Clear lands on the edge that commits the load into the register file;
  // a same-cycle reissue to that register takes priority.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned i = 0; i < NUM_GPR; i++) begin
      if (we && (wb_src == gpu_pkg::WB_LD) && (A3 == ADDR_W'(i))) pending_nxt[i] = 1'b0;
      if (issue_load && (issue_rd == ADDR_W'(i)))                 pending_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

`ifdef WB_DROP_CNT_EN
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  always_comb begin
    drop_inc = 2'(alu_valid && !alu_wr)
             + 2'(pop && !head_ok)
             + 2'(issue_load && (issue_rd >= GPR_N));
    drop_sum = {1'b0, drop_cnt} + 9'(drop_inc);
  end

  always_ff @(posedge clk) begin
    if (!reset) drop_cnt <= '0;
    else        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int NGPR  = 13;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        issue_load;
  logic [3:0]  issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_rd;
  logic [15:0] ld_data;
  logic        reg_en;
  logic        we;
  logic [3:0]  A3;
  logic [15:0] WD;
  logic [12:0] pending;
  logic [2:0]  ldq_count;
  logic [7:0]  drop_cnt;

  writeback_arbiter #(
    .DATA_W    (16),
    .ADDR_W    (4),
    .NUM_GPR   (13),
    .LDQ_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .issue_load (issue_load),
    .issue_rd   (issue_rd),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .reg_en     (reg_en),
    .we         (we),
    .A3         (A3),
    .WD         (WD),
    .pending    (pending),
    .ldq_count  (ldq_count),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of pending returns, register-file port view,
  // bitmask of outstanding loads and a drop tally.
  int   q_rd[$];
  int   q_data[$];
  bit   m_we;
  bit   m_from_ld;
  int   m_a3;
  int   m_wd;
  bit [12:0] m_pend;
  int   m_drop;

  task automatic model_reset();
    q_rd.delete();
    q_data.delete();
    m_we = 0; m_from_ld = 0; m_a3 = 0; m_wd = 0; m_pend = '0; m_drop = 0;
  endtask

  task automatic tick();
    bit exp_ready;
    int drops;
    bit [12:0] p;
    exp_ready = (q_rd.size() < DEPTH);
    check_eq("ld_ready", ld_ready, exp_ready);
    drops = 0;
    if (!reset) begin
      model_reset();
    end else begin
      p = m_pend;
      if (m_we && m_from_ld) p[m_a3] = 1'b0;
      if (issue_load) begin
        if (issue_rd < NGPR) p[issue_rd] = 1'b1;
        else drops++;
      end
      m_pend = p;
      m_we = 0;
      m_from_ld = 0;
      if (alu_valid && alu_rd < NGPR) begin
        m_we = 1; m_a3 = alu_rd; m_wd = alu_data;
      end else begin
        if (alu_valid) drops++;
        if (q_rd.size() > 0) begin
          int r, d;
          r = q_rd.pop_front();
          d = q_data.pop_front();
          if (r < NGPR) begin
            m_we = 1; m_from_ld = 1; m_a3 = r; m_wd = d;
          end else drops++;
        end
      end
      if (ld_valid && exp_ready) begin
        q_rd.push_back(ld_rd);
        q_data.push_back(ld_data);
      end
`ifdef WB_DROP_CNT_EN
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
`endif
    end
    @(posedge clk);
    #1;
    check_eq("we", we, m_we);
    check_eq("reg_en", reg_en, m_we);
    check_eq("A3", A3, m_a3);
    check_eq("WD", WD, m_wd);
    check_eq("pending", pending, m_pend);
    check_eq("ldq_count", ldq_count, q_rd.size());
    check_eq("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    issue_load = 0; issue_rd = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
  endtask

  initial begin
    int got[$];
    int next_ld;
    int we_seen;
    bit [12:0] pend_before;
    int exp_drop;

    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    tick();

    // Reset with full queue, outstanding load and a return still offered
    issue_load = 1; issue_rd = 4'd7;
    alu_valid = 1; alu_rd = 4'd0; alu_data = 16'h1111;
    ld_valid = 1;
    for (int i = 0; i < 5; i++) begin
      issue_load = (i == 0);
      ld_rd = 4'(i + 1); ld_data = 16'(16'hA000 + i);
      tick();
    end
    check_eq("pre_reset_full", ldq_count, 3'd4);
    reset = 1'b0;
    tick();
    check_eq("rst_we", we, 1'b0);
    check_eq("rst_count", ldq_count, 3'd0);
    check_eq("rst_pending", pending, 13'd0);
    check_eq("rst_ready", ld_ready, 1'b1);
    reset = 1'b1;
    idle_inputs();
    tick();

    // ALU path
    alu_valid = 1; alu_rd = 4'd3; alu_data = 16'hBEEF;
    tick();
    check_eq("alu_we", we, 1'b1);
    check_eq("alu_A3", A3, 4'd3);
    check_eq("alu_WD", WD, 16'hBEEF);
    idle_inputs();
    tick();
    check_eq("alu_we_off", we, 1'b0);
    check_eq("alu_hold_WD", WD, 16'hBEEF);

    // Load path and scoreboard
    issue_load = 1; issue_rd = 4'd5;
    tick();
    check_eq("ld_pend_set", pending[5], 1'b1);
    idle_inputs();
    ld_valid = 1; ld_rd = 4'd5; ld_data = 16'h1234;
    tick();
    check_eq("ld_no_early_we", we, 1'b0);
    idle_inputs();
    tick();
    check_eq("ld_we", we, 1'b1);
    check_eq("ld_A3", A3, 4'd5);
    check_eq("ld_WD", WD, 16'h1234);
    check_eq("ld_pend_during_we", pending[5], 1'b1);
    tick();
    check_eq("ld_pend_clr", pending[5], 1'b0);

    // Contention and full queue
    next_ld = 1;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      alu_valid = 1; alu_rd = 4'(6 + (c % 3)); alu_data = 16'(16'hC000 + c);
      ld_valid = (next_ld <= 5); ld_rd = 4'(next_ld); ld_data = 16'(16'hD000 + next_ld);
      acc = ld_valid && ld_ready;
      tick();
      if (acc) next_ld++;
    end
    check_eq("cont_accepts", next_ld - 1, 4);
    check_eq("cont_not_ready", ld_ready, 1'b0);
    alu_valid = 0;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      bit acc;
      ld_valid = (next_ld <= 5); ld_rd = 4'(next_ld); ld_data = 16'(16'hD000 + next_ld);
      acc = ld_valid && ld_ready;
      tick();
      if (acc) next_ld++;
      if (we) got.push_back(A3);
    end
    check_eq("cont_num_writes", got.size(), 5);
    for (int k = 0; k < 5; k++)
      check_eq("cont_order", (k < got.size()) ? got[k] : -1, k + 1);
    idle_inputs();
    repeat (3) tick();

    // Special registers
    reset = 1'b0; tick(); reset = 1'b1;
    pend_before = pending;
    we_seen = 0;
    alu_valid = 1; alu_rd = 4'd14; alu_data = 16'h5555;
    tick(); we_seen += we;
    idle_inputs();
    issue_load = 1; issue_rd = 4'd15;
    tick(); we_seen += we;
    idle_inputs();
    ld_valid = 1; ld_rd = 4'd13; ld_data = 16'h7777;
    tick(); we_seen += we;
    idle_inputs();
    repeat (3) begin tick(); we_seen += we; end
    check_eq("spec_no_we", we_seen, 0);
    check_eq("spec_pending", pending, pend_before);
`ifdef WB_DROP_CNT_EN
    exp_drop = 3;
`else
    exp_drop = 0;
`endif
    check_eq("spec_drop_cnt", drop_cnt, exp_drop);

    // Same-cycle clear and set of one scoreboard bit
    issue_load = 1; issue_rd = 4'd2;
    tick();
    idle_inputs();
    ld_valid = 1; ld_rd = 4'd2; ld_data = 16'h2222;
    tick();
    idle_inputs();
    tick();
    check_eq("simul_we", we, 1'b1);
    issue_load = 1; issue_rd = 4'd2;
    tick();
    check_eq("simul_set_wins", pending[2], 1'b1);
    idle_inputs();
    tick();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      reset      = ($urandom_range(0, 199) != 0);
      alu_valid  = ($urandom_range(0, 2) == 0);
      alu_rd     = 4'($urandom_range(0, 15));
      alu_data   = 16'($urandom);
      issue_load = ($urandom_range(0, 3) == 0);
      issue_rd   = 4'($urandom_range(0, 15));
      ld_valid   = ($urandom_range(0, 1) == 0);
      ld_rd      = 4'($urandom_range(0, 15));
      ld_data    = 16'($urandom);
      tick();
    end
    idle_inputs();
    reset = 1'b1;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
